// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline write-back slice:
//   - load_type_e : LoadType encodings carried down the pipe with each load
//   - REG_ZERO    : architectural $0, never written
//   - STARVE_LIMIT_DEF : default blocked-cycle threshold for Starve_Req
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } load_type_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Purely combinational little-endian load alignment.
//   word      in  raw memory word
//   load_type in  LoadType encoding (unknown encodings behave as LW)
//   offset    in  byte address bits [1:0] of the load
//   result    out sign/zero-extended byte or halfword, or the whole word
// Only meaningful for WIDTH = 32.
// -----------------------------------------------------------------------------
module load_align
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word,
    input  logic [2:0]       load_type,
    input  logic [1:0]       offset,
    output logic [WIDTH-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword select uses offset[1] only; offset[0] is ignored for LH/LHU.
    assign byte_sel = word[{offset, 3'b000} +: 8];
    assign half_sel = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: result gets a default first so no path through the case leaves
        // it unassigned; a missing default here would infer a latch.
        result = word;
        case (load_type)
            LT_LB:   result = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            LT_LBU:  result = {{(WIDTH-8){1'b0}}, byte_sel};
            LT_LH:   result = {{(WIDTH-16){half_sel[15]}}, half_sel};
            LT_LHU:  result = {{(WIDTH-16){1'b0}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// MIPS write-back stage: M/W pipeline register, result select, and
// arbitration of the single register-file write port between the pipeline
// and a one-entry buffer fed by a long-latency external producer.
//
// Ports:
//   clk, reset (async, active-low)
//   Stall_W, Flush_W               M/W register control (flush wins)
//   RegWrite_M .. WriteReg_M       MEM-stage instruction fields
//   Ext_Valid/Ext_Ready/Ext_Reg/Ext_Data  external write handshake
//   RegWrite_W/WriteReg_W/Result_W register-file write port
//   Pend_Valid/Pend_Reg            buffered write status for the hazard unit
//   Starve_Req                     buffer blocked >= STARVE_LIMIT cycles
//
// Build option: define WB_SUBWORD_LOAD_EN for LB/LBU/LH/LHU alignment;
// otherwise LoadType_M is ignored and loads return the raw word.
// -----------------------------------------------------------------------------
module wb_stage
    import mips_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall_W,
    input  logic             Flush_W,
    input  logic             RegWrite_M,
    input  logic             MemtoReg_M,
    input  logic [2:0]       LoadType_M,
    input  logic [WIDTH-1:0] ALUOut_M,
    input  logic [WIDTH-1:0] ReadData_M,
    input  logic [4:0]       WriteReg_M,
    input  logic             Ext_Valid,
    output logic             Ext_Ready,
    input  logic [4:0]       Ext_Reg,
    input  logic [WIDTH-1:0] Ext_Data,
    output logic             RegWrite_W,
    output logic [4:0]       WriteReg_W,
    output logic [WIDTH-1:0] Result_W,
    output logic             Pend_Valid,
    output logic [4:0]       Pend_Reg,
    output logic             Starve_Req
);

    // M/W pipeline register
    logic             mw_regwrite;
    logic             mw_memtoreg;
    logic [WIDTH-1:0] mw_aluout;
    logic [WIDTH-1:0] mw_readdata;
    logic [4:0]       mw_writereg;

    // External write buffer and starvation counter
    logic             buf_valid;
    logic [4:0]       buf_reg;
    logic [WIDTH-1:0] buf_data;
    logic [CNT_W-1:0] starve_cnt;

    logic             pipe_wr;
    logic             drain;
    logic             discard;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] pipe_result;

`ifdef WB_SUBWORD_LOAD_EN
    logic [2:0] mw_loadtype;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mw_loadtype <= LT_LW;
        else if (!Flush_W && !Stall_W)
            mw_loadtype <= LoadType_M;
    end

    load_align #(.WIDTH(WIDTH)) u_align (
        .word      (mw_readdata),
        .load_type (mw_loadtype),
        .offset    (mw_aluout[1:0]),
        .result    (load_data)
    );
`else
    logic unused_load_type;
    assign unused_load_type = ^LoadType_M;
    assign load_data        = mw_readdata;
`endif

    // Flush only needs to kill the write enable; the data fields are
    // don't-care for a bubble, so they simply hold.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is updated with <= so every register samples
        // the pre-edge values regardless of statement order.
        if (!reset) begin
            mw_regwrite <= 1'b0;
            mw_memtoreg <= 1'b0;
            mw_aluout   <= '0;
            mw_readdata <= '0;
            mw_writereg <= REG_ZERO;
        end else if (Flush_W) begin
            mw_regwrite <= 1'b0;
        end else if (!Stall_W) begin
            mw_regwrite <= RegWrite_M;
            mw_memtoreg <= MemtoReg_M;
            mw_aluout   <= ALUOut_M;
            mw_readdata <= ReadData_M;
            mw_writereg <= WriteReg_M;
        end
    end

    assign pipe_result = mw_memtoreg ? load_data : mw_aluout;
    assign pipe_wr     = mw_regwrite && (mw_writereg != REG_ZERO);

    // Buffer leaves by draining through an idle port, or by being overwritten
    // by a younger pipeline write to the same register (WAW).
    assign drain   = buf_valid && !pipe_wr;
    assign discard = buf_valid && pipe_wr && (mw_writereg == buf_reg);

    always_comb begin
        RegWrite_W = 1'b0;
        WriteReg_W = REG_ZERO;
        Result_W   = '0;
        if (pipe_wr) begin
            RegWrite_W = 1'b1;
            WriteReg_W = mw_writereg;
            Result_W   = pipe_result;
        end else if (buf_valid) begin
            RegWrite_W = 1'b1;
            WriteReg_W = buf_reg;
            Result_W   = buf_data;
        end
    end

    // Accept only when empty, so accept and drain are mutually exclusive.
    // A transfer to $0 completes the handshake but is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_reg   <= REG_ZERO;
            buf_data  <= '0;
        end else if (drain || discard) begin
            buf_valid <= 1'b0;
        end else if (!buf_valid && Ext_Valid && (Ext_Reg != REG_ZERO)) begin
            buf_valid <= 1'b1;
            buf_reg   <= Ext_Reg;
            buf_data  <= Ext_Data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (!buf_valid || drain || discard)
            starve_cnt <= '0;
        else if (starve_cnt != {CNT_W{1'b1}})
            starve_cnt <= starve_cnt + CNT_W'(1);
    end

    assign Ext_Ready  = !buf_valid;
    assign Pend_Valid = buf_valid;
    assign Pend_Reg   = buf_reg;
    assign Starve_Req = (starve_cnt >= CNT_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Directed bench for wb_stage. Every expected register-file write is pushed
// to a scoreboard when its stimulus is driven; a falling-edge monitor pops
// and compares each write the DUT issues, and demands an idle port whenever
// nothing is expected. Status outputs are checked directly between steps.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             Stall_W, Flush_W;
    logic             RegWrite_M, MemtoReg_M;
    logic [2:0]       LoadType_M;
    logic [WIDTH-1:0] ALUOut_M, ReadData_M;
    logic [4:0]       WriteReg_M;
    logic             Ext_Valid, Ext_Ready;
    logic [4:0]       Ext_Reg;
    logic [WIDTH-1:0] Ext_Data;
    logic             RegWrite_W;
    logic [4:0]       WriteReg_W;
    logic [WIDTH-1:0] Result_W;
    logic             Pend_Valid;
    logic [4:0]       Pend_Reg;
    logic             Starve_Req;

    wb_stage #(.WIDTH(WIDTH), .STARVE_LIMIT(8), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .Stall_W    (Stall_W),
        .Flush_W    (Flush_W),
        .RegWrite_M (RegWrite_M),
        .MemtoReg_M (MemtoReg_M),
        .LoadType_M (LoadType_M),
        .ALUOut_M   (ALUOut_M),
        .ReadData_M (ReadData_M),
        .WriteReg_M (WriteReg_M),
        .Ext_Valid  (Ext_Valid),
        .Ext_Ready  (Ext_Ready),
        .Ext_Reg    (Ext_Reg),
        .Ext_Data   (Ext_Data),
        .RegWrite_W (RegWrite_W),
        .WriteReg_W (WriteReg_W),
        .Result_W   (Result_W),
        .Pend_Valid (Pend_Valid),
        .Pend_Reg   (Pend_Reg),
        .Starve_Req (Starve_Req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]       rd;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  vectors     = 0;
    int  miscompares = 0;
    bit  mon_en      = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        Stall_W    = 1'b0;
        Flush_W    = 1'b0;
        RegWrite_M = 1'b0;
        MemtoReg_M = 1'b0;
        LoadType_M = 3'b000;
        WriteReg_M = 5'd0;
        Ext_Valid  = 1'b0;
        Ext_Reg    = 5'd0;
        Ext_Data   = '0;
    endtask

    task automatic drive_pipe(input logic mtr, input logic [2:0] lt,
                              input logic [31:0] alu, input logic [31:0] rd_data,
                              input logic [4:0] wr);
        RegWrite_M = 1'b1;
        MemtoReg_M = mtr;
        LoadType_M = lt;
        ALUOut_M   = alu;
        ReadData_M = rd_data;
        WriteReg_M = wr;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        e.rd   = r;
        e.data = d;
        sb.push_back(e);
    endtask

    // Register file samples on the falling edge; so does the monitor.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (sb.size() == 0) begin
                check("idle_port", RegWrite_W, 1'b0);
            end else if (RegWrite_W) begin
                mon_e = sb.pop_front();
                check("sb_reg", WriteReg_W, mon_e.rd);
                check("sb_data", Result_W, mon_e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Load alignment vectors: ReadData = 0x80FF_7F01
    logic [2:0]  lt_tab  [8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    logic [1:0]  off_tab [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd3, 2'd1};
    logic [31:0] exp_tab [8] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80,
                                 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};

    initial begin
        logic [31:0] exp_ld;
        rst_n    = 1'b0;
        ALUOut_M = '0;
        ReadData_M = '0;
        idle();

        // Reset state
        #12;
        check("rst_regwrite", RegWrite_W, 1'b0);
        check("rst_writereg", WriteReg_W, 5'd0);
        check("rst_result", Result_W, 32'h0);
        check("rst_pend_valid", Pend_Valid, 1'b0);
        check("rst_pend_reg", Pend_Reg, 5'd0);
        check("rst_starve", Starve_Req, 1'b0);
        check("rst_ext_ready", Ext_Ready, 1'b1);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // ALU write to $8
        tick();
        drive_pipe(1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd8);
        push(5'd8, 32'h0000_1234);
        tick();
        check("add_regwrite", RegWrite_W, 1'b1);
        check("add_writereg", WriteReg_W, 5'd8);
        check("add_result", Result_W, 32'h0000_1234);

        // Load alignment, back to back
        for (int i = 0; i < 8; i++) begin
`ifdef WB_SUBWORD_LOAD_EN
            exp_ld = exp_tab[i];
`else
            exp_ld = 32'h80FF_7F01;
`endif
            drive_pipe(1'b1, lt_tab[i], 32'h0000_1000 | {30'd0, off_tab[i]}, 32'h80FF_7F01, 5'd7);
            push(5'd7, exp_ld);
            tick();
            check("load_result", Result_W, exp_ld);
        end
        idle();
        tick();

        // Write to $0 is never issued
        drive_pipe(1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd0);
        tick();
        check("r0_no_write", RegWrite_W, 1'b0);
        idle();
        tick();

        // External write with idle pipeline
        Ext_Valid = 1'b1;
        Ext_Reg   = 5'd9;
        Ext_Data  = 32'hDEAD_BEEF;
        push(5'd9, 32'hDEAD_BEEF);
        tick();
        Ext_Valid = 1'b0;
        check("ext_pend_valid", Pend_Valid, 1'b1);
        check("ext_pend_reg", Pend_Reg, 5'd9);
        check("ext_ready_low", Ext_Ready, 1'b0);
        check("ext_regwrite", RegWrite_W, 1'b1);
        check("ext_writereg", WriteReg_W, 5'd9);
        check("ext_result", Result_W, 32'hDEAD_BEEF);
        tick();
        check("ext_drained", Pend_Valid, 1'b0);
        check("ext_ready_high", Ext_Ready, 1'b1);

        // External write to $0 is discarded
        Ext_Valid = 1'b1;
        Ext_Reg   = 5'd0;
        Ext_Data  = 32'h1111_2222;
        tick();
        Ext_Valid = 1'b0;
        check("ext_r0_pend", Pend_Valid, 1'b0);
        check("ext_r0_ready", Ext_Ready, 1'b1);
        tick();

        // Starvation: buffer $9 blocked by pipeline writes to $10
        Ext_Valid = 1'b1;
        Ext_Reg   = 5'd9;
        Ext_Data  = 32'h9999_0009;
        drive_pipe(1'b0, 3'b000, 32'd0, 32'h0, 5'd10);
        push(5'd10, 32'd0);
        tick();
        Ext_Valid = 1'b0;
        check("starve_pend", Pend_Valid, 1'b1);
        check("starve_init", Starve_Req, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            drive_pipe(1'b0, 3'b000, j, 32'h0, 5'd10);
            push(5'd10, j);
            tick();
            check("starve_wait_pend", Pend_Valid, 1'b1);
            check("starve_req", Starve_Req, (j >= 8) ? 1'b1 : 1'b0);
        end
        idle();
        push(5'd9, 32'h9999_0009);
        tick();
        check("starve_drain_reg", WriteReg_W, 5'd9);
        check("starve_held", Starve_Req, 1'b1);
        tick();
        check("starve_clear_pend", Pend_Valid, 1'b0);
        check("starve_drop", Starve_Req, 1'b0);

        // WAW: pipeline writes $9 while buffer holds $9
        Ext_Valid = 1'b1;
        Ext_Reg   = 5'd9;
        Ext_Data  = 32'hAAAA_AAAA;
        drive_pipe(1'b0, 3'b000, 32'h0000_0005, 32'h0, 5'd9);
        push(5'd9, 32'h0000_0005);
        tick();
        Ext_Valid = 1'b0;
        idle();
        check("waw_result", Result_W, 32'h0000_0005);
        check("waw_pend_before", Pend_Valid, 1'b1);
        tick();
        check("waw_discarded", Pend_Valid, 1'b0);
        tick();

        // Stall holds the M/W register
        drive_pipe(1'b0, 3'b000, 32'h0000_0013, 32'h0, 5'd13);
        push(5'd13, 32'h0000_0013);
        tick();
        Stall_W = 1'b1;
        drive_pipe(1'b0, 3'b000, 32'h0000_0014, 32'h0, 5'd14);
        push(5'd13, 32'h0000_0013);
        tick();
        check("stall_hold_reg", WriteReg_W, 5'd13);
        idle();
        tick();

        // Flush wins over stall
        Flush_W = 1'b1;
        Stall_W = 1'b1;
        drive_pipe(1'b0, 3'b000, 32'h0000_0012, 32'h0, 5'd12);
        tick();
        check("flush_regwrite", RegWrite_W, 1'b0);
        idle();
        tick();

        // Reset while the buffer is valid
        Ext_Valid = 1'b1;
        Ext_Reg   = 5'd11;
        Ext_Data  = 32'hBBBB_0011;
        drive_pipe(1'b0, 3'b000, 32'h0000_0010, 32'h0, 5'd10);
        push(5'd10, 32'h0000_0010);
        tick();
        idle();
        check("rstmid_pend_before", Pend_Valid, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_pend", Pend_Valid, 1'b0);
        check("rstmid_regwrite", RegWrite_W, 1'b0);
        check("rstmid_ready", Ext_Ready, 1'b1);
        check("rstmid_pend_reg", Pend_Reg, 5'd0);
        tick();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check("rstmid_after_pend", Pend_Valid, 1'b0);
        tick();

        check("sb_empty", sb.size(), 0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
